// File: rtl/press_pattern_emitter_pkg.sv
// Shared constants for the press pattern emitter and its timer.
// Press durations live here so LONG > threshold > SHORT is held in one place.
package press_pattern_emitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_e;

    localparam int unsigned MAX_SYMBOLS = 8;

    localparam int unsigned DEF_SHORT_CYCLES    = 50_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 250_000_000;
    localparam int unsigned DEF_GAP_CYCLES      = 50_000_000;
    localparam int unsigned LONG_PRESS_THRESHOLD = 200_000_000;

    function automatic logic [3:0] clamp_count(input logic [3:0] c);
        return (c > 4'(MAX_SYMBOLS)) ? 4'(MAX_SYMBOLS) : c;
    endfunction

endpackage

// File: rtl/press_pattern_emitter_if.sv
// Control/status bundle between a sequencer and the press pattern emitter.
interface press_pattern_emitter_if;

    logic       start_i;
    logic [7:0] pattern_i;
    logic [3:0] count_i;
    logic       abort_i;
    logic       line_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, pattern_i, count_i, abort_i,
        input  line_o, busy_o, done_o
    );

    modport slave (
        input  start_i, pattern_i, count_i, abort_i,
        output line_o, busy_o, done_o
    );

endinterface

// File: rtl/press_duration_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module press_duration_timer #(
    parameter int CNT_W = 28
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/press_pattern_emitter.sv
// Plays back 1..8 short/long presses on one line, each followed by a gap.
module press_pattern_emitter
    import press_pattern_emitter_pkg::*;
#(
    parameter int          CNT_W        = 28,
    parameter int unsigned SHORT_CYCLES = DEF_SHORT_CYCLES,
    parameter int unsigned LONG_CYCLES  = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    press_pattern_emitter_if.slave  bus
);

    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] pat_q, pat_d;
    logic [3:0] rem_q, rem_d;
    logic       line_q, line_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [3:0]       req_cnt;

    press_duration_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign req_cnt = clamp_count(bus.count_i);

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Abort beats a simultaneous start, dropping the request.
                if (bus.start_i && !bus.abort_i) begin
                    pat_d = bus.pattern_i;
                    rem_d = req_cnt;
                    if (req_cnt == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_MARK;
                        tmr_load = 1'b1;
                        tmr_val  = bus.pattern_i[0] ? LONG_LD : SHORT_LD;
                    end
                end
            end
            ST_MARK: begin
                if (bus.abort_i) begin
                    state_d  = ST_IDLE;
                    rem_d    = 4'd0;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = ST_SPACE;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            ST_SPACE: begin
                if (bus.abort_i) begin
                    state_d  = ST_IDLE;
                    rem_d    = 4'd0;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    if (rem_q > 4'd1) begin
                        pat_d    = pat_q >> 1;
                        rem_d    = rem_q - 4'd1;
                        state_d  = ST_MARK;
                        tmr_load = 1'b1;
                        tmr_val  = pat_q[1] ? LONG_LD : SHORT_LD;
                    end else begin
                        rem_d   = 4'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        line_d = (state_d == ST_MARK);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            line_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.line_o = line_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_press_pattern_emitter.sv
// Scoreboard bench: stimulus queues expected {line,busy,done} per cycle.
module tb_press_pattern_emitter;

    typedef struct {
        logic [2:0] v;
        string      tag;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    press_pattern_emitter_if bus();

    press_pattern_emitter #(
        .CNT_W        (8),
        .SHORT_CYCLES (3),
        .LONG_CYCLES  (8),
        .GAP_CYCLES   (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_no  = 0;
    string tag     = "reset";

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [2:0] got;
            e   = q.pop_front();
            got = {bus.line_o, bus.busy_o, bus.done_o};
            n_tests++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {line,busy,done} got=%b exp=%b",
                         e.tag, e.cyc, got, e.v);
            end
        end
    end

    task automatic cyc(input logic l, input logic b, input logic d);
        exp_t e;
        @(posedge clk);
        cyc_no++;
        e.v   = {l, b, d};
        e.tag = tag;
        e.cyc = cyc_no;
        q.push_back(e);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        rst_i       = 1'b0;
    endtask

    task automatic run(input logic l, input logic b, input logic d,
                       input int n);
        repeat (n) cyc(l, b, d);
    endtask

    task automatic start(input logic [7:0] p, input logic [3:0] c,
                         input string name);
        tag           = name;
        cyc_no        = 0;
        bus.start_i   = 1'b1;
        bus.pattern_i = p;
        bus.count_i   = c;
    endtask

    initial begin
        rst_i         = 1'b1;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.pattern_i = '0;
        bus.count_i   = '0;
        run(0, 0, 0, 3);

        start(8'b10, 4'd2, "basic");
        run(1, 1, 0, 3);
        run(0, 1, 0, 2);
        run(1, 1, 0, 8);
        run(0, 1, 0, 2);
        run(0, 0, 1, 1);
        run(0, 0, 0, 2);

        start(8'h00, 4'd0, "empty");
        run(0, 0, 1, 1);
        run(0, 0, 0, 3);

        start(8'h00, 4'd12, "clamp");
        for (int i = 0; i < 8; i++) begin
            run(1, 1, 0, 3);
            run(0, 1, 0, 2);
        end
        run(0, 0, 1, 1);
        run(0, 0, 0, 2);

        start(8'b1, 4'd1, "start_busy");
        run(1, 1, 0, 5);
        bus.start_i   = 1'b1;
        bus.pattern_i = 8'b0;
        bus.count_i   = 4'd1;
        run(1, 1, 0, 3);
        run(0, 1, 0, 2);
        run(0, 0, 1, 1);
        bus.start_i   = 1'b1;
        bus.pattern_i = 8'b0;
        bus.count_i   = 4'd1;
        tag           = "back_to_back";
        run(1, 1, 0, 3);
        run(0, 1, 0, 2);
        run(0, 0, 1, 1);
        run(0, 0, 0, 2);

        start(8'b1, 4'd1, "abort_mark");
        run(1, 1, 0, 4);
        bus.abort_i = 1'b1;
        run(0, 0, 0, 4);

        start(8'b0, 4'd1, "after_abort");
        run(1, 1, 0, 3);
        run(0, 1, 0, 2);
        run(0, 0, 1, 1);
        run(0, 0, 0, 1);

        start(8'b1, 4'd1, "abort_start_idle");
        bus.abort_i = 1'b1;
        run(0, 0, 0, 3);

        start(8'b11, 4'd2, "reset_mid");
        run(1, 1, 0, 3);
        rst_i = 1'b1;
        run(0, 0, 0, 3);

        start(8'b10, 4'd2, "after_reset");
        run(1, 1, 0, 3);
        run(0, 1, 0, 2);
        run(1, 1, 0, 8);
        run(0, 1, 0, 2);
        run(0, 0, 1, 1);
        run(0, 0, 0, 2);

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d exp=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
